// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for seven_seg_scanner: segment inputs, scan controls and board drive.
interface seven_seg_scanner_if;
  logic       en;
  logic       load;
  logic [6:0] seg5;
  logic [6:0] seg4;
  logic [6:0] seg3;
  logic [6:0] seg2;
  logic [6:0] seg1;
  logic [6:0] seg0;
  logic [5:0] an;
  logic [6:0] seg_out;
  logic       frame_done;
  logic       busy;

  modport master (
    output en, load, seg5, seg4, seg3, seg2, seg1, seg0,
    input  an, seg_out, frame_done, busy
  );

  modport slave (
    input  en, load, seg5, seg4, seg3, seg2, seg1, seg0,
    output an, seg_out, frame_done, busy
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Six-digit common-anode scanner with a frame-synchronous shadow buffer.
// Optional per-slot blanking gap is enabled by defining SCAN_BLANK_EN.
module seven_seg_scanner #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  seven_seg_scanner_if.slave bus
);

  localparam int unsigned NDIG  = 6;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 3;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2 || BLANK == 0 || BLANK >= DIV) begin : g_bad_param
    $error("seven_seg_scanner: illegal DIV/BLANK combination");
  end

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                     state_q, state_d;
  logic [DIG_W-1:0]           digit_q, digit_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic [NDIG-1:0][SEG_W-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]            an_q, an_d;
  logic [SEG_W-1:0]           seg_q, seg_d;
  logic                       fd_q, fd_d;

  logic [NDIG-1:0][SEG_W-1:0] seg_in_c;
  logic                       last_cnt_c;
  logic                       boundary_c;
  logic                       drive_c;

  assign seg_in_c   = {bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  assign last_cnt_c = (cnt_q == CNT_W'(DIV - 1));
  assign boundary_c = (state_q == SCAN) && bus.en &&
                      (digit_q == DIG_W'(NDIG - 1)) && last_cnt_c;

`ifdef SCAN_BLANK_EN
  assign drive_c = (state_q == SCAN) && (cnt_q >= CNT_W'(BLANK));
`else
  assign drive_c = (state_q == SCAN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      an_q     <= '1;
      seg_q    <= '1;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fd_q     <= fd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    an_d     = '1;
    seg_d    = '1;
    fd_d     = 1'b0;

    // Display drive reflects the current slot; registering gives the one-clock lag.
    if (drive_c) begin
      an_d  = ~(NDIG'(1) << digit_q);
      seg_d = ~shadow_q[digit_q];
    end

    unique case (state_q)
      IDLE: begin
        digit_d = '0;
        cnt_d   = '0;
        // A load left pending from SCAN is honoured here as well.
        if (bus.load || pend_q) begin
          shadow_d = seg_in_c;
        end
        pend_d = 1'b0;
        if (bus.en) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!bus.en) begin
          state_d = IDLE;
          digit_d = '0;
          cnt_d   = '0;
          if (bus.load) begin
            pend_d = 1'b1;
          end
        end else begin
          if (last_cnt_c) begin
            cnt_d   = '0;
            digit_d = (digit_q == DIG_W'(NDIG - 1)) ? '0 : digit_q + DIG_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Frame boundary: capture only here so a frame never mixes old and new digits.
          if (boundary_c) begin
            fd_d = 1'b1;
            if (bus.load || pend_q) begin
              shadow_d = seg_in_c;
            end
            pend_d = 1'b0;
          end else if (bus.load) begin
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.an         = an_q;
  assign bus.seg_out    = seg_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = pend_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a time-based reference model (DIV=4, BLANK=1).
module tb_seven_seg_scanner;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;
  localparam int unsigned NDIG  = 6;
  localparam int unsigned FRAME = NDIG * DIV;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  seven_seg_scanner_if bus_if ();

  seven_seg_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is elapsed scan time, not a digit/count pair.
  bit         mdl_scan;
  bit         mdl_pend;
  int         mdl_m;
  logic [6:0] mdl_sh [NDIG];
  logic [6:0] seg_in [NDIG];
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_fd;
  logic       exp_busy;
  int         md, mc;
  bit         mbnd;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mdl_scan = 1'b0;
        mdl_pend = 1'b0;
        mdl_m    = 0;
        for (int i = 0; i < NDIG; i++) mdl_sh[i] = 7'h00;
        exp_an   = 6'h3F;
        exp_seg  = 7'h7F;
        exp_fd   = 1'b0;
        exp_busy = 1'b0;
      end else begin
        seg_in = '{bus_if.seg0, bus_if.seg1, bus_if.seg2, bus_if.seg3, bus_if.seg4, bus_if.seg5};
        md = (mdl_m / DIV) % NDIG;
        mc = mdl_m % DIV;
        exp_an  = 6'h3F;
        exp_seg = 7'h7F;
        if (mdl_scan && !(BLANK_ON && mc < int'(BLANK))) begin
          exp_an  = ~(6'b000001 << md);
          exp_seg = ~mdl_sh[md];
        end
        mbnd   = mdl_scan && bus_if.en && (md == NDIG - 1) && (mc == DIV - 1);
        exp_fd = mbnd;
        if (!mdl_scan) begin
          if (bus_if.load || mdl_pend) mdl_sh = seg_in;
          mdl_pend = 1'b0;
          mdl_scan = bus_if.en;
          mdl_m    = 0;
        end else if (!bus_if.en) begin
          mdl_scan = 1'b0;
          mdl_m    = 0;
          if (bus_if.load) mdl_pend = 1'b1;
        end else begin
          mdl_m++;
          if (mbnd) begin
            if (bus_if.load || mdl_pend) mdl_sh = seg_in;
            mdl_pend = 1'b0;
          end else if (bus_if.load) begin
            mdl_pend = 1'b1;
          end
        end
        exp_busy = mdl_pend;
      end
    end
  end

  // Continuous comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && chk_on) begin
        chk("model_an",   32'(bus_if.an),         32'(exp_an));
        chk("model_seg",  32'(bus_if.seg_out),    32'(exp_seg));
        chk("model_fd",   32'(bus_if.frame_done), 32'(exp_fd));
        chk("model_busy", 32'(bus_if.busy),       32'(exp_busy));
      end
    end
  end

  // Step until the DUT's internal slot position equals (d, c); bounded.
  task automatic wait_pos(input int d, input int c);
    int n = 0;
    while (!(mdl_scan && (mdl_m % FRAME) == d * DIV + c) && n < 4 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 4 * FRAME) chk("wait_pos_timeout", 32'(n), 32'(0));
  endtask

  task automatic tick_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_load();
    bus_if.load = 1'b1;
    @(posedge clk);
    #1;
    bus_if.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [5:0] an_tbl [NDIG];
  logic [5:0] an_exp;

  initial begin
    an_tbl = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    rst_n  = 1'b0;
    bus_if.en   = 1'b0;
    bus_if.load = 1'b0;
    bus_if.seg5 = 7'h00; bus_if.seg4 = 7'h00; bus_if.seg3 = 7'h00;
    bus_if.seg2 = 7'h00; bus_if.seg1 = 7'h00; bus_if.seg0 = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",   32'(bus_if.an),         32'(6'h3F));
    chk("rst_seg",  32'(bus_if.seg_out),    32'(7'h7F));
    chk("rst_fd",   32'(bus_if.frame_done), 32'(1'b0));
    chk("rst_busy", 32'(bus_if.busy),       32'(1'b0));
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // IDLE load, then scan order over one full frame
    bus_if.seg0 = 7'h3F;
    bus_if.seg1 = 7'h06;
    @(posedge clk);
    #1;
    pulse_load();
    chk("idle_busy", 32'(bus_if.busy), 32'(1'b0));
    bus_if.en = 1'b1;
    tick_neg();
    chk("en_k_dark", 32'(bus_if.an), 32'(6'h3F));
    for (int i = 0; i < int'(FRAME); i++) begin
      tick_neg();
      an_exp = an_tbl[i / DIV];
      if (BLANK_ON && (i % DIV) == 0) an_exp = 6'h3F;
      chk("order_an", 32'(bus_if.an), 32'(an_exp));
      if (i == 1)  chk("order_seg_d0", 32'(bus_if.seg_out), 32'(7'h40));
      if (i == 5)  chk("order_seg_d1", 32'(bus_if.seg_out), 32'(7'h79));
      if (i == 22) chk("order_fd_pre", 32'(bus_if.frame_done), 32'(1'b0));
      if (i == 23) chk("order_fd",     32'(bus_if.frame_done), 32'(1'b1));
    end

    // Tear-free load during digit 2
    wait_pos(2, 1);
    bus_if.seg0 = 7'h06;
    bus_if.seg5 = 7'h6D;
    pulse_load();
    @(negedge clk);
    chk("tear_busy_set", 32'(bus_if.busy), 32'(1'b1));
    wait_pos(5, 2);
    @(negedge clk);
    chk("tear_old_an",  32'(bus_if.an),      32'(6'h1F));
    chk("tear_old_seg", 32'(bus_if.seg_out), 32'(7'h7F));
    chk("tear_busy_hold", 32'(bus_if.busy),  32'(1'b1));
    wait_pos(0, 2);
    @(negedge clk);
    chk("tear_new_an",  32'(bus_if.an),      32'(6'h3E));
    chk("tear_new_seg", 32'(bus_if.seg_out), 32'(7'h79));
    chk("tear_busy_clr", 32'(bus_if.busy),   32'(1'b0));
    wait_pos(5, 2);
    @(negedge clk);
    chk("tear_new_d5", 32'(bus_if.seg_out), 32'(7'h12));

    // Load exactly on the boundary cycle
    wait_pos(5, 3);
    bus_if.seg1 = 7'h5B;
    pulse_load();
    @(negedge clk);
    chk("bnd_busy", 32'(bus_if.busy),       32'(1'b0));
    chk("bnd_fd",   32'(bus_if.frame_done), 32'(1'b1));
    chk("bnd_an",   32'(bus_if.an),         32'(6'h1F));
    wait_pos(1, 2);
    @(negedge clk);
    chk("bnd_seg_d1", 32'(bus_if.seg_out), 32'(7'h24));
    chk("bnd_an_d1",  32'(bus_if.an),      32'(6'h3D));

    // en drop during digit 4 with a load pending
    wait_pos(4, 1);
    bus_if.seg2 = 7'h4F;
    pulse_load();
    bus_if.en = 1'b0;
    @(negedge clk);
    chk("drop_busy0", 32'(bus_if.busy), 32'(1'b1));
    chk("drop_an0",   32'(bus_if.an),   32'(6'h2F));
    tick_neg();
    chk("drop_an1",   32'(bus_if.an),   32'(6'h2F));
    chk("drop_busy1", 32'(bus_if.busy), 32'(1'b1));
    tick_neg();
    chk("drop_an2",   32'(bus_if.an),      32'(6'h3F));
    chk("drop_seg2",  32'(bus_if.seg_out), 32'(7'h7F));
    chk("drop_busy2", 32'(bus_if.busy),    32'(1'b0));
    bus_if.en = 1'b1;
    tick_neg();
    chk("reen_dark", 32'(bus_if.an), 32'(6'h3F));
    tick_neg();
    chk("reen_an", 32'(bus_if.an), 32'(BLANK_ON ? 6'h3F : 6'h3E));
    wait_pos(2, 2);
    @(negedge clk);
    chk("reen_an_d2",  32'(bus_if.an),      32'(6'h3B));
    chk("reen_seg_d2", 32'(bus_if.seg_out), 32'(7'h30));

    // Asynchronous reset during digit 3 with a load pending
    wait_pos(2, 1);
    bus_if.seg3 = 7'h66;
    pulse_load();
    wait_pos(3, 1);
    chk("pre_rst_busy", 32'(bus_if.busy), 32'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an",   32'(bus_if.an),         32'(6'h3F));
    chk("arst_seg",  32'(bus_if.seg_out),    32'(7'h7F));
    chk("arst_busy", 32'(bus_if.busy),       32'(1'b0));
    chk("arst_fd",   32'(bus_if.frame_done), 32'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_neg();
    chk("post_rst_e1", 32'(bus_if.an), 32'(6'h3F));
    tick_neg();
    chk("post_rst_e2", 32'(bus_if.an), 32'(BLANK_ON ? 6'h3F : 6'h3E));
    chk("post_rst_seg", 32'(bus_if.seg_out), 32'(7'h7F));
    wait_pos(5, 3);
    tick_neg();
    chk("post_rst_fd", 32'(bus_if.frame_done), 32'(1'b1));
    tick_neg();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the six-digit seven-segment display. It sits directly downstream of the display controller:
- consumes the six decoded segment patterns `seg5`..`seg0`;
- snapshots them into a shadow buffer at frame boundaries, so digits never tear;
- scans one digit at a time onto the shared cathode bus and per-digit anodes of a common-anode board;
- optionally inserts a blanking gap to suppress ghosting.

## Interface
- `DIV`, 50000 — clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, 1000 — blanking cycles at the start of each slot; legal range 1..DIV-1. Used only with `SCAN_BLANK_EN`.
- `clk` in 1 — single clock, rising-edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `en` in 1 — scan enable; low turns the display dark.
- `load` in 1 — one-cycle request to capture the current `seg5`..`seg0`.
- `seg5`..`seg0` in 7 each — segment patterns {g,f,e,d,c,b,a}; bit=1 means lit.
- `an` out 6 — anode enables, active-low; `an[i]` selects digit i.
- `seg_out` out 7 — cathodes, active-low; this is the bitwise inverse of the shadowed pattern.
- `frame_done` out 1 — one-cycle pulse at the end of each digit-5 slot.
- `busy` out 1 — high while a captured load is pending.

## Operation
- **States:**
  - IDLE: `en`=0. Counters are held at `digit`=0, `cnt`=0, and outputs are dark.
  - SCAN: `en`=1.
  - The IDLE→SCAN and SCAN→IDLE decisions use `en` as sampled each edge.
- **Slot counter `cnt`:**
  - Counts 0..DIV-1.
  - At `cnt`=DIV-1 it wraps to 0 and `digit` advances 0→1→…→5→0.
- **Shadow buffer (6×7 bits), in SCAN:**
  - A `load` pulse sets a sticky pending flag; `busy` mirrors this flag.
  - The shadow is written from `seg5`..`seg0` on the edge where `digit`=5 and `cnt`=DIV-1 (the frame boundary). The pending flag clears on that same edge.
  - Inputs are sampled on that boundary edge, not at the time of the `load` pulse.
  - If `load` arrives on the boundary cycle itself, it is captured on that boundary.
  - Further `load` pulses while pending are merged into the one pending capture.
- **Shadow buffer, in IDLE:** `load` writes the shadow on the next edge and sets no pending flag.
- **Display drive:**
  - Active digit i: `an`=~(1<<i) and `seg_out`=~shadow[i].
  - All other anodes are 1.
  - When dark: `an`=6'h3F, `seg_out`=7'h7F.
- **Leaving SCAN:**
  - `en` falling mid-frame causes a return to IDLE next edge; counters reset.
  - A pending load is kept and is then captured on the next IDLE edge.
- **`frame_done`:** pulses when the digit-5 slot ends (frame boundary edge), including on frames where no capture occurs.
- **Reset:**
  - Outputs: `an`=6'h3F, `seg_out`=7'h7F, `frame_done`=0, `busy`=0.
  - Internal state: shadow all 0, `digit`=0, `cnt`=0, state IDLE.
  - Reset asserted mid-frame takes effect immediately, with no completion of the current slot.

## Timing
- `an`, `seg_out` and `frame_done` are registered and lag the internal `(digit, cnt)` by exactly one clock.
- **Enabling:** `en` sampled high at edge k puts the block in SCAN with `digit`=0, `cnt`=0 at edge k+1. Without blanking, `an`=6'b111110 appears at edge k+2.
- **Slot length:** each digit is driven for exactly DIV cycles when blanking is off.
- **Frame period:** 6·DIV cycles. `frame_done` has a period of 6·DIV.
- **Capture latency:** a newly captured shadow becomes visible in the first digit-0 slot after the boundary.
- **Disabling:** `en` sampled low at edge k puts the outputs dark at edge k+2.

## Configuration
- **`SCAN_BLANK_EN` defined:**
  - In each slot, for `cnt` < BLANK, `an`=6'h3F and `seg_out`=7'h7F.
  - For the remaining DIV-BLANK cycles the digit is driven.
  - Counters, frame period and `frame_done` are unchanged.
- **`SCAN_BLANK_EN` undefined:**
  - No blanking; the digit is driven for all DIV cycles.
  - The `BLANK` parameter is ignored.

## Test plan
All scenarios use DIV=4 and BLANK=1.
- **Reset mid-scan:** assert `rst_n`=0 while `digit`=3 → outputs are asynchronously `an`=3F, `seg_out`=7F, `busy`=0. After release with `en`=1, `an`=3E appears at the 2nd edge.
- **Scan order:** load in IDLE with `seg0`=7'h3F ("0") and `seg1`=7'h06 ("1"), then `en`=1 → `an` steps 3E,3D,3B,37,2F,1F, 4 cycles each. `seg_out` is 7'h40 during digit 0 and 7'h79 during digit 1. `frame_done` pulses every 24 cycles.
- **Tear-free load:**
  - Pulse `load` during the digit-2 slot with `seg0` changed to 7'h06 → `busy` stays 1 until the boundary; digits 3–5 of that frame still show old data.
  - The next digit-0 slot shows `seg_out`=7'h79, and `busy` falls on the boundary edge.
- **Load on boundary cycle:** pulse `load` exactly when `digit`=5 and `cnt`=3 → captured on that edge; `busy` never visible high afterwards.
- **en drop mid-frame:** `en`=0 during digit 4 with a load pending → dark 2 edges later; the shadow updates on the next edge and `busy`=0. Re-enabling restarts at digit 0.
- **Blanking with `SCAN_BLANK_EN`:** first cycle of each slot `an`=3F; remaining 3 cycles drive the digit; `frame_done` period is still 24 cycles.
